// File: rtl/quadencoder_filt_pkg.sv
// quadencoder_filt shared definitions
// mode encodings, direction values and the quadrature step decoder
package quadenc_pkg;

  localparam int QM_X4 = 0;
  localparam int QM_X2 = 1;
  localparam int QM_X1 = 2;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } step_t;

  // position of an AB state in the forward cycle 00-10-11-01
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] r;
    r = 2'd0;
    unique case (ab)
      2'b00: r = 2'd0;
      2'b10: r = 2'd1;
      2'b11: r = 2'd2;
      2'b01: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // distance 1 = forward, 3 = reverse, 2 = both channels moved
  function automatic step_t step_decode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    step_t     s;
    logic [1:0] d;
    s = '0;
    d = gray_idx(cur) - gray_idx(prev);
    unique case (1'b1)
      (d == 2'd1): begin
        s.valid = 1'b1;
        s.dir   = DIR_FWD;
      end
      (d == 2'd3): begin
        s.valid = 1'b1;
        s.dir   = DIR_REV;
      end
      (d == 2'd2): s.illegal = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quadencoder_filt_if.sv
// quadencoder_filt pin/result bundle
// master drives encoder pins and controls, slave is the decoder
interface quadencoder_filt_if #(
  parameter int BITS        = 32,
  parameter int PERIOD_BITS = 24
);

  logic                    a;
  logic                    b;
  logic                    z;
  logic                    index_enable;
  logic                    error_clr;
  logic                    index_out;
  logic signed [BITS-1:0]  position;
  logic signed [BITS-1:0]  latched_position;
  logic signed [15:0]      revs;
  logic [PERIOD_BITS-1:0]  period;
  logic                    direction;
  logic                    error;

  modport master (
    output a, b, z, index_enable, error_clr,
    input  index_out, position, latched_position,
    input  revs, period, direction, error
  );

  modport slave (
    input  a, b, z, index_enable, error_clr,
    output index_out, position, latched_position,
    output revs, period, direction, error
  );

endinterface

// File: rtl/quadencoder_filt_filter.sv
// quad_input_filter: 2-FF synchroniser plus depth filter
// output only moves after DEPTH consecutive differing samples
module quad_input_filter #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = 5;

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // any agreeing sample restarts the run count
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEPTH - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // synchroniser and filter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o = filt_q;

endmodule

// File: rtl/quadencoder_filt.sv
// quadencoder_filt: filtered quadrature decoder with index,
// revolution count, step period and illegal-transition flag
module quadencoder_filt
  import quadenc_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int QUAD_MODE    = 0,
  parameter int FILTER_DEPTH = 4,
  parameter int PERIOD_BITS  = 24
) (
  input logic clk,
  input logic rst_n,
  quadencoder_filt_if.slave bus
);

  logic fa;
  logic fb;
  logic fz;

  quad_input_filter #(.DEPTH(FILTER_DEPTH)) u_fa (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.a),
    .q_o   (fa)
  );

  quad_input_filter #(.DEPTH(FILTER_DEPTH)) u_fb (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.b),
    .q_o   (fb)
  );

  quad_input_filter #(.DEPTH(FILTER_DEPTH)) u_fz (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.z),
    .q_o   (fz)
  );

  logic [1:0]             ab_q;
  logic                   z_q;
  logic                   ie_q;
  logic                   ie_prev_q;
  logic                   armed_q;
  logic                   armed_d;
  logic [BITS-1:0]        pos_q;
  logic [BITS-1:0]        pos_d;
  logic [BITS-1:0]        lat_q;
  logic [BITS-1:0]        lat_d;
  logic [15:0]            revs_q;
  logic [15:0]            revs_d;
  logic [PERIOD_BITS-1:0] period_q;
  logic [PERIOD_BITS-1:0] period_d;
  logic [PERIOD_BITS-1:0] timer_q;
  logic [PERIOD_BITS-1:0] timer_d;
  logic                   dir_q;
  logic                   dir_d;
  logic                   err_q;
  logic                   err_d;

  step_t st;
  logic  count;
  logic  step_dir;
  logic  z_rise;
  logic  ie_rise;

  // step qualification for the selected decode mode
  always_comb begin
    st       = step_decode(ab_q, {fa, fb});
    count    = st.valid;
    step_dir = st.dir;
    if (QUAD_MODE == QM_X2) begin
      count = st.valid & (ab_q[1] ^ fa);
    end else if (QUAD_MODE == QM_X1) begin
      count    = st.valid & ~ab_q[1] & fa;
      step_dir = fb ? DIR_REV : DIR_FWD;
    end
  end

  assign z_rise  = fz & ~z_q;
  assign ie_rise = ie_q & ~ie_prev_q;

  // position, index, revs, period and error next state
  always_comb begin
    pos_d    = pos_q;
    lat_d    = lat_q;
    revs_d   = revs_q;
    dir_d    = dir_q;
    period_d = period_q;
    armed_d  = armed_q;
    err_d    = err_q;
    timer_d  = (timer_q == '1) ? timer_q
                               : timer_q + PERIOD_BITS'(1);
    if (count) begin
      pos_d    = (step_dir == DIR_FWD) ? pos_q + BITS'(1)
                                       : pos_q - BITS'(1);
      dir_d    = step_dir;
      period_d = timer_q;
      timer_d  = PERIOD_BITS'(1);
    end
    if (z_rise) begin
      revs_d = (dir_q == DIR_FWD) ? revs_q + 16'd1
                                  : revs_q - 16'd1;
    end
    if (armed_q) begin
      if (z_rise) begin
        lat_d   = pos_q;
        pos_d   = '0;
        armed_d = 1'b0;
      end else if (!ie_q) begin
        armed_d = 1'b0;
      end
    end else if (ie_rise) begin
      armed_d = 1'b1;
    end
    if (bus.error_clr) begin
      err_d = 1'b0;
    end
    if (st.illegal) begin
      err_d = 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q      <= 2'b00;
      z_q       <= 1'b0;
      ie_q      <= 1'b0;
      ie_prev_q <= 1'b0;
      armed_q   <= 1'b0;
      pos_q     <= '0;
      lat_q     <= '0;
      revs_q    <= '0;
      period_q  <= '1;
      timer_q   <= '1;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ab_q      <= {fa, fb};
      z_q       <= fz;
      ie_q      <= bus.index_enable;
      ie_prev_q <= ie_q;
      armed_q   <= armed_d;
      pos_q     <= pos_d;
      lat_q     <= lat_d;
      revs_q    <= revs_d;
      period_q  <= period_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign bus.index_out        = armed_q;
  assign bus.position         = pos_q;
  assign bus.latched_position = lat_q;
  assign bus.revs             = revs_q;
  assign bus.period           = period_q;
  assign bus.direction        = dir_q;
  assign bus.error            = err_q;

endmodule
